// File: rtl/led_pkg.sv
// Shared types and constants for the LED fade output stage.
package led_pkg;

  // Default brightness resolution; the top can override it per instance.
  localparam int unsigned PwmBitsDefault = 8;

  typedef logic [PwmBitsDefault-1:0] level_t;

  typedef enum logic [1:0] {
    StOff,
    StRising,
    StOn,
    StFalling
  } chan_state_e;

  // The DS_* pins light an LED when driven low.
  localparam logic LedActiveLow = 1'b1;

endpackage

// File: rtl/led_fade_chan.sv
// One LED channel: brightness level, fade FSM and registered PWM output bit.
module led_fade_chan
  import led_pkg::*;
#(
  parameter int unsigned PwmBits = PwmBitsDefault
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [PwmBits-1:0] target_i,
  input  logic               step_i,
  input  logic [PwmBits-1:0] pwm_cnt_i,
  input  logic               en_i,
  input  logic               pattern_i,
  output logic               led_o,
  output logic               busy_o
);

  localparam logic [PwmBits-1:0] Max   = {PwmBits{1'b1}};
  localparam logic [PwmBits-1:0] MaxM1 = Max - 1'b1;
  localparam logic [PwmBits-1:0] One   = {{(PwmBits-1){1'b0}}, 1'b1};

  chan_state_e        state_q, state_d;
  logic [PwmBits-1:0] level_q, level_d;
  logic               led_q, led_d;
  logic               tgt_on;
  logic               lit;

  assign tgt_on = (target_i == Max);

  // Next level/state: bypass tracks the target, fade mode moves one LSB per step.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (!en_i) begin
      level_d = target_i;
      state_d = tgt_on ? StOn : StOff;
    end else if (step_i) begin
      unique case (state_q)
        StOff: begin
          if (tgt_on) begin
            level_d = level_q + 1'b1;
            state_d = (level_q == MaxM1) ? StOn : StRising;
          end
        end
        StRising: begin
          // A reversal only turns the direction; the level holds for this step.
          if (!tgt_on) begin
            state_d = StFalling;
          end else begin
            level_d = level_q + 1'b1;
            if (level_q == MaxM1) state_d = StOn;
          end
        end
        StOn: begin
          if (!tgt_on) begin
            level_d = level_q - 1'b1;
            state_d = (level_q == One) ? StOff : StFalling;
          end
        end
        StFalling: begin
          if (tgt_on) begin
            state_d = StRising;
          end else begin
            level_d = level_q - 1'b1;
            if (level_q == One) state_d = StOff;
          end
        end
        default: state_d = StOff;
      endcase
    end
  end

  // Lit decision and output polarity; bypass forwards the synchronized pattern.
  always_comb begin
    lit   = (level_q == Max) | (pwm_cnt_i < level_q);
    led_d = en_i ? (lit ^ LedActiveLow) : pattern_i;
  end

  // Bypass never reports busy, so a pattern change there cannot flag a fade.
  assign busy_o = en_i & (level_q != target_i);
  assign led_o  = led_q;

  // Channel state registers; reset leaves the LED dark.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StOff;
      level_q <= '0;
      led_q   <= LedActiveLow;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      led_q   <= led_d;
    end
  end

endmodule

// File: rtl/led_fade_pwm.sv
// LED output stage: synchronizes the shifter pattern and fades each LED by PWM.
module led_fade_pwm
  import led_pkg::*;
#(
  parameter int unsigned N_LED    = 4,
  parameter int unsigned PWM_BITS = PwmBitsDefault,
  parameter int unsigned FADE_DIV = 94
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic [N_LED-1:0] led_in,
  input  logic             en,
  output logic [N_LED-1:0] led_out,
  output logic             busy
);

  localparam logic [PWM_BITS-1:0] Max      = {PWM_BITS{1'b1}};
  localparam int unsigned         FadeW    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [FadeW-1:0]    FadeLast = FadeW'(FADE_DIV - 1);

  logic [N_LED-1:0]    sync1_q, led_s_q;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [FadeW-1:0]    fade_cnt_q, fade_cnt_d;
  logic                busy_q, busy_d;
  logic                wrap, step;
  logic [N_LED-1:0]    chan_busy;

  // Period counter and fade divider; step marks a period boundary.
  always_comb begin
    wrap       = (pwm_cnt_q == Max);
    step       = wrap && (fade_cnt_q == FadeLast);
    pwm_cnt_d  = pwm_cnt_q + 1'b1;
    fade_cnt_d = fade_cnt_q;
    if (wrap) fade_cnt_d = step ? '0 : fade_cnt_q + 1'b1;
    busy_d     = |chan_busy;
  end

  for (genvar i = 0; i < N_LED; i++) begin : g_chan
    logic [PWM_BITS-1:0] target;
    assign target = (led_s_q[i] ^ LedActiveLow) ? Max : '0;

    led_fade_chan #(
      .PwmBits(PWM_BITS)
    ) u_chan (
      .clk_i    (CLK),
      .rst_ni   (RST_n),
      .target_i (target),
      .step_i   (step),
      .pwm_cnt_i(pwm_cnt_q),
      .en_i     (en),
      .pattern_i(led_s_q[i]),
      .led_o    (led_out[i]),
      .busy_o   (chan_busy[i])
    );
  end

  assign busy = busy_q;

  // Two-flop synchronizer for the slow-domain pattern, plus shared counters.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      sync1_q    <= '1;
      led_s_q    <= '1;
      pwm_cnt_q  <= '0;
      fade_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= led_in;
      led_s_q    <= sync1_q;
      pwm_cnt_q  <= pwm_cnt_d;
      fade_cnt_q <= fade_cnt_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Directed bench for led_fade_pwm with a 16-cycle period and a step every 32 cycles.
module tb_led_fade_pwm;

  logic       clk;
  logic       rst_n;
  logic [3:0] led_in;
  logic       en;
  logic [3:0] led_out;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // Channel 0 level history, sampled every negedge.
  logic [3:0] lvl_prev;
  int n_up, n_down, n_jump, n_offbnd;

  led_fade_pwm #(
    .N_LED   (4),
    .PWM_BITS(4),
    .FADE_DIV(2)
  ) dut (
    .CLK    (clk),
    .RST_n  (rst_n),
    .led_in (led_in),
    .en     (en),
    .led_out(led_out),
    .busy   (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    n_up = 0; n_down = 0; n_jump = 0; n_offbnd = 0;
    lvl_prev = dut.g_chan[0].u_chan.level_q;
  endtask

  task automatic tick();
    logic [3:0] l;
    @(negedge clk);
    l = dut.g_chan[0].u_chan.level_q;
    if (l != lvl_prev) begin
      if (l == lvl_prev + 4'd1) n_up++;
      else if (l == lvl_prev - 4'd1) n_down++;
      else n_jump++;
      if (dut.pwm_cnt_q != 4'd0) n_offbnd++;
      lvl_prev = l;
    end
  endtask

  initial begin
    bit got, done, bad;
    int cyc;
    logic [15:0] pat;

    // Reset applies with no clock edge.
    rst_n = 1'b1; led_in = 4'h0; en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk(led_out, 4'hF, "rst_led");
    chk(busy, 1'b0, "rst_busy");
    led_in = 4'hF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (led_out !== 4'hF || busy !== 1'b0) bad = 1;
    end
    chk(bad, 1'b0, "idle_dark");

    // Rise on channel 0.
    clear_mon();
    led_in = 4'hE; cyc = 0; got = 0;
    for (int i = 0; i < 3 && !got; i++) begin
      tick(); cyc++;
      if (busy) got = 1;
    end
    chk(got, 1'b1, "rise_busy");
    done = 0; bad = 0;
    while (!done && cyc < 15*32+19) begin
      tick(); cyc++;
      if (led_out[3:1] !== 3'b111) bad = 1;
      if (led_out[0] === 1'b0 && busy === 1'b0) done = 1;
    end
    chk(done, 1'b1, "rise_done");
    chk(n_up, 15, "rise_steps");
    chk(n_jump + n_down, 0, "rise_jump");
    chk(n_offbnd, 0, "rise_boundary");
    for (int i = 0; i < 32; i++) begin
      tick();
      if (led_out !== 4'hE) bad = 1;
    end
    chk(bad, 1'b0, "rise_hold");

    // Fall from full and measure the duty cycle at level 5.
    clear_mon();
    led_in = 4'hF; done = 0;
    for (int i = 0; i < 600 && !done; i++) begin
      tick();
      if (lvl_prev == 4'd5 && dut.pwm_cnt_q == 4'd0) done = 1;
    end
    chk(done, 1'b1, "duty_find");
    for (int k = 0; k < 16; k++) begin
      tick();
      pat[k] = led_out[0];
    end
    chk(pat, 16'hFFE0, "duty_5");
    done = 0;
    for (int i = 0; i < 600 && !done; i++) begin
      tick();
      if (busy === 1'b0) done = 1;
    end
    chk(done, 1'b1, "fall_done");
    chk(lvl_prev, 4'd0, "fall_level");
    chk(n_down, 15, "fall_steps");
    chk(n_jump, 0, "fall_jump");

    // Reversal at level 8 continues from the current level.
    clear_mon();
    led_in = 4'hE; done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick();
      if (lvl_prev == 4'd8) done = 1;
    end
    chk(done, 1'b1, "rev_reach8");
    led_in = 4'hF;
    clear_mon();
    done = 0;
    for (int i = 0; i < 70 && !done; i++) begin
      tick();
      if (lvl_prev != 4'd8) done = 1;
    end
    chk(lvl_prev, 4'd7, "rev_first");
    done = 0;
    for (int i = 0; i < 9*32+10 && !done; i++) begin
      tick();
      if (busy === 1'b0) done = 1;
    end
    chk(done, 1'b1, "rev_busy_fall");
    chk(lvl_prev, 4'd0, "rev_level");
    chk(n_down, 8, "rev_steps");
    chk(n_up + n_jump, 0, "rev_jump");
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (led_out[0] !== 1'b1) bad = 1;
    end
    chk(bad, 1'b0, "rev_dark");

    // Bypass: three-cycle pass-through, then re-enable without a transient.
    en = 1'b0; led_in = 4'hC;
    repeat (6) tick();
    led_in = 4'h9;
    tick(); chk(led_out, 4'hC, "byp_d1");
    tick(); chk(led_out, 4'hC, "byp_d2");
    tick(); chk(led_out, 4'h9, "byp_d3");
    chk(busy, 1'b0, "byp_busy");
    en = 1'b1; bad = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (led_out !== 4'h9 || busy !== 1'b0) bad = 1;
    end
    chk(bad, 1'b0, "byp_reenable");

    // Reset in the middle of a rise.
    led_in = 4'hF; done = 0;
    for (int i = 0; i < 600 && !done; i++) begin
      tick();
      if (busy === 1'b0 && i > 4) done = 1;
    end
    chk(done, 1'b1, "mrst_settle");
    clear_mon();
    led_in = 4'hE; done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      if (lvl_prev == 4'd6) done = 1;
    end
    chk(done, 1'b1, "mrst_reach6");
    rst_n = 1'b0;
    #1;
    chk(led_out, 4'hF, "mrst_led");
    chk(busy, 1'b0, "mrst_busy");
    chk(dut.g_chan[0].u_chan.level_q, 4'd0, "mrst_level");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    done = 0;
    for (int i = 0; i < 15*32+40 && !done; i++) begin
      tick();
      if (lvl_prev == 4'd15) done = 1;
    end
    chk(done, 1'b1, "mrst_rise_done");
    chk(n_up, 15, "mrst_steps");
    chk(n_jump + n_down, 0, "mrst_jump");
    repeat (2) tick();
    chk(led_out, 4'hE, "mrst_led_on");
    chk(busy, 1'b0, "mrst_busy_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
